addsub_nibble_sequencer: RTL and testbench

- Shares one 4-bit ripple add/sub slice between two requesters.
- Each request is a multi-nibble (4*NIBBLES-bit) add or subtract. The block executes it serially, one nibble per clock, LSB first, chaining carry through a register.
- Round-robin arbitration between the two requesters; a valid/ready handshake on every port.
- Sits between the arithmetic slice and any two clients that need wide add/sub but cannot each afford a full-width adder.

---
 rtl/addsub_nibble_sequencer_pkg.sv | 17 +
 rtl/addsub_nibble_slice.sv | 28 ++
 rtl/addsub_nibble_sequencer.sv | 117 +++++++++++
 tb/tb_addsub_nibble_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_nibble_sequencer_pkg.sv
// Shared constants and types for the nibble-serial add/sub sequencer.
package addsub_nibble_sequencer_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index counter; at least one bit even for a single nibble.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_nibble_slice.sv
// Combinational 4-bit ripple adder slice; exposes the carry into bit 3 for overflow detection.
module addsub_nibble_slice
  import addsub_nibble_sequencer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/addsub_nibble_sequencer.sv
// Two-requester round-robin front end that runs wide add/sub one nibble per clock
// through a single shared 4-bit slice, LSB first, with the carry chained in a register.
module addsub_nibble_sequencer
  import addsub_nibble_sequencer_pkg::*;
#(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_ovf
);

  localparam int unsigned IW = idx_width(NIBBLES);

  state_t                              state;
  logic [IW-1:0]                       idx;
  logic                                carry_q;
  logic                                last_grant;
  logic                                op_sub;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    op_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    op_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    res_q;

  logic                accept_c;
  logic                grant1_c;
  logic [NIBBLE_W-1:0] slice_b_c;
  logic [NIBBLE_W-1:0] slice_s_c;
  logic                slice_cout_c;
  logic                slice_c3_c;

  // Requester 1 wins when alone, or when both ask and requester 0 went last.
  assign grant1_c   = req1_valid & (~req0_valid | ~last_grant);
  assign accept_c   = (state == IDLE) & ~rst & (req0_valid | req1_valid);
  assign req0_ready = accept_c & ~grant1_c;
  assign req1_ready = accept_c & grant1_c;

  assign slice_b_c  = op_b[idx] ^ {NIBBLE_W{op_sub}};
  assign rsp_result = res_q;

  addsub_nibble_slice u_slice (
    .a    (op_a[idx]),
    .b    (slice_b_c),
    .cin  (carry_q),
    .s    (slice_s_c),
    .cout (slice_cout_c),
    .c3   (slice_c3_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      carry_q    <= 1'b0;
      last_grant <= 1'b1;
      op_sub     <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      res_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_a       <= grant1_c ? req1_a : req0_a;
            op_b       <= grant1_c ? req1_b : req0_b;
            op_sub     <= grant1_c ? req1_sub : req0_sub;
            carry_q    <= grant1_c ? req1_sub : req0_sub;
            idx        <= '0;
            rsp_id     <= grant1_c;
            last_grant <= grant1_c;
            state      <= RUN;
          end
        end
        RUN: begin
          res_q[idx] <= slice_s_c;
          carry_q    <= slice_cout_c;
          if (idx == IW'(NIBBLES - 1)) begin
            idx       <= '0;
            rsp_carry <= slice_cout_c;
            rsp_ovf   <= slice_c3_c ^ slice_cout_c;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Randomized bench for addsub_nibble_sequencer, scored against an arithmetic reference model.
module tb_addsub_nibble_sequencer;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf;
  logic [W-1:0] rsp_result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic model_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: unsigned and signed integer arithmetic on the whole operands.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    longint ua, ub, sa, sb, sres, full, modv;
    logic   carry, ovf;
    modv = longint'(1) << W;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua >= modv / 2) ? ua - modv : ua;
    sb   = (ub >= modv / 2) ? ub - modv : ub;
    if (sub) begin
      full  = (ua - ub + modv) % modv;
      carry = (ua >= ub);
      sres  = sa - sb;
    end else begin
      full  = (ua + ub) % modv;
      carry = (ua + ub) >= modv;
      sres  = sa + sb;
    end
    ovf = (sres >= modv / 2) || (sres < -(modv / 2));
    return {carry, ovf, W'(full)};
  endfunction

  // One full transaction starting in an IDLE cycle (called at posedge+1).
  task automatic do_op(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic s0, input logic v1, input logic [W-1:0] a1,
                       input logic [W-1:0] b1, input logic s1, input int bp);
    logic         g;
    logic [W+1:0] exp;
    g = (v0 && v1) ? ~model_last : v1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    #1;
    check("req0_ready_idle", req0_ready, !g);
    check("req1_ready_idle", req1_ready, g);
    exp = g ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
    model_last = g;
    @(posedge clk); #1;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
      rsp_ready = 1'($urandom);
      #1;
      check("ready_run", {req1_ready, req0_ready}, 2'b00);
      check("rsp_valid_run", rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_id", rsp_id, g);
    check("rsp_result", rsp_result, exp[W-1:0]);
    check("rsp_carry", rsp_carry, exp[W+1]);
    check("rsp_ovf", rsp_ovf, exp[W]);
    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_stable", {rsp_id, rsp_carry, rsp_ovf, rsp_result}, {g, exp[W+1], exp[W], exp[W-1:0]});
      check("bp_ready", {req1_ready, req0_ready}, 2'b00);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_drop", rsp_valid, 1'b0);
    rsp_ready = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    model_last = 1'b1;
    #1;
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_result}, '0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fairness: both held valid, grants alternate and are spaced NIBBLES+2 cycles.
    begin
      int last_acc;
      last_acc = 0;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      #1;
      for (int g = 0; g < 4; g++) begin
        int waited;
        waited = 0;
        while (!(req0_ready || req1_ready) && waited < 20) begin
          @(posedge clk); #1; waited++;
        end
        if (waited >= 20) check("fair_timeout", 1'b0, 1'b1);
        else begin
          check("fair_grant", {req1_ready, req0_ready}, (g % 2 == 0) ? 2'b01 : 2'b10);
          if (g > 0) check("fair_spacing", 32'(cyc - last_acc), NIBBLES + 2);
          last_acc = cyc;
          @(posedge clk); #1;
        end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      model_last = 1'b1;
      repeat (NIBBLES + 3) @(posedge clk);
      #1;
      check("fair_idle", rsp_valid, 1'b0);
    end

    do_op(1'b1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, '0, '0, 1'b0, 0);
    do_op(1'b0, '0, '0, 1'b0, 1'b1, 16'h0005, 16'h0007, 1'b1, 0);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, '0, '0, 1'b0, 1);
    do_op(1'b0, '0, '0, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 3);

    // Reset in the middle of RUN drops the operation.
    req1_valid = 1'b1; req1_a = 16'hABCD; req1_b = 16'h1234; req1_sub = 1'b0;
    #1;
    check("mid_rst_grant", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_stale_rsp", rsp_valid, 1'b0);
    end
    do_op(1'b1, 16'h4321, 16'h1111, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      logic v0, v1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      do_op(v0, W'($urandom), W'($urandom), 1'($urandom),
            v1, W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
